// File: rtl/alu_op_issuer.sv
// alu_op_issuer: buffers ALU commands in a FIFO, issues them to an external ALU,
// returns tagged result/zero/err. Optional perf counters: ALU_ISSUER_PERF_EN.
//
// Ports:
//   clk, reset (sync, active high)
//   cmd_valid/cmd_ready, cmd_a, cmd_b, cmd_op, cmd_tag  : command input
//   alu_a, alu_b, alu_control -> ALU ; alu_result, alu_zero <- ALU
//   rsp_valid/rsp_ready, rsp_data, rsp_zero, rsp_tag, rsp_err : response
//   count (FIFO occupancy), busy
//   perf_ops, perf_err (only with ALU_ISSUER_PERF_EN)
module alu_op_issuer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [31:0]            cmd_a,
    input  logic [31:0]            cmd_b,
    input  logic [3:0]             cmd_op,
    input  logic [TAG_W-1:0]       cmd_tag,
    output logic [31:0]            alu_a,
    output logic [31:0]            alu_b,
    output logic [3:0]             alu_control,
    input  logic [31:0]            alu_result,
    input  logic                   alu_zero,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_data,
    output logic                   rsp_zero,
    output logic [TAG_W-1:0]       rsp_tag,
    output logic                   rsp_err,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy
`ifdef ALU_ISSUER_PERF_EN
    ,
    output logic [31:0]            perf_ops,
    output logic [31:0]            perf_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 32 + 32 + 4 + TAG_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t           r_state;
    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [TAG_W-1:0] r_iss_tag;

    logic          w_push;
    logic          w_pop;
    logic          w_hs;
    logic          w_legal;
    logic [EW-1:0] w_head;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
            4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100:
                op_legal = 1'b1;
            default:
                op_legal = 1'b0;
        endcase
    endfunction

    assign cmd_ready = (r_count != CW'(DEPTH));
    assign count     = r_count;
    assign busy      = (r_state != S_IDLE) || (r_count != '0);

    assign w_push  = cmd_valid && cmd_ready;
    assign w_hs    = rsp_valid && rsp_ready;
    assign w_head  = r_mem[r_rptr];
    assign w_legal = op_legal(alu_control);

    // Pop only from IDLE, or from RESP in the cycle the response is taken.
    assign w_pop = (r_count != '0) &&
                   ((r_state == S_IDLE) || ((r_state == S_RESP) && w_hs));

    // Storage needs no reset; occupancy is tracked by pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {cmd_a, cmd_b, cmd_op, cmd_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // alu_* double as the issue registers and keep their value outside ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            r_iss_tag   <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_zero    <= 1'b0;
            rsp_tag     <= '0;
            rsp_err     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        {alu_a, alu_b, alu_control, r_iss_tag} <= w_head;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rsp_valid <= 1'b1;
                    rsp_tag   <= r_iss_tag;
                    if (w_legal) begin
                        rsp_data <= alu_result;
                        rsp_zero <= alu_zero;
                        rsp_err  <= 1'b0;
                    end else begin
                        rsp_data <= '0;
                        rsp_zero <= 1'b0;
                        rsp_err  <= 1'b1;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (w_hs) begin
                        rsp_valid <= 1'b0;
                        if (w_pop) begin
                            {alu_a, alu_b, alu_control, r_iss_tag} <= w_head;
                            r_state <= S_ISSUE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ISSUER_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ops <= '0;
            perf_err <= '0;
        end else if (w_hs) begin
            perf_ops <= perf_ops + 32'd1;
            if (rsp_err) begin
                perf_err <= perf_err + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: directed and random checks of alu_op_issuer against a
// queue-based reference model; an arithmetic ALU model plays the external ALU.
module tb_alu_op_issuer;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [3:0]       cmd_op;
    logic [TAG_W-1:0] cmd_tag;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [3:0]       alu_control;
    logic [31:0]      alu_result;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_zero;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic [CW-1:0]    count;
    logic             busy;
`ifdef ALU_ISSUER_PERF_EN
    logic [31:0]      perf_ops;
    logic [31:0]      perf_err;
`endif

    alu_op_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_op      (cmd_op),
        .cmd_tag     (cmd_tag),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_zero    (rsp_zero),
        .rsp_tag     (rsp_tag),
        .rsp_err     (rsp_err),
        .count       (count),
        .busy        (busy)
`ifdef ALU_ISSUER_PERF_EN
        ,
        .perf_ops    (perf_ops),
        .perf_err    (perf_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      d;
        logic             z;
        logic             e;
        logic [TAG_W-1:0] t;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_rsp    = 0;
    exp_t q[$];
    logic hold     = 1'b0;
    logic [31:0]      hold_d;
    logic [TAG_W-1:0] hold_t;
    logic [31:0] last_d;
    logic        last_z;
    logic        last_e;
    logic        rand_ready = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {err, zero, data} from the operation's arithmetic meaning.
    function automatic logic [33:0] ref_alu(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [3:0] op);
        logic [31:0] d;
        logic        e;
        d = '0;
        e = 1'b0;
        case (op)
            4'd0:    d = a & b;
            4'd1:    d = a | b;
            4'd2:    d = a + b;
            4'd6:    d = a - b;
            4'd7:    d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:    d = (a < b) ? 32'd1 : 32'd0;
            4'd9:    d = a ^ b;
            4'd10:   d = a << b[4:0];
            4'd11:   d = a >> b[4:0];
            4'd12:   d = $signed(a) >>> b[4:0];
            default: e = 1'b1;
        endcase
        return {e, (!e && d == 32'd0), e ? 32'd0 : d};
    endfunction

    // External ALU: garbage on illegal codes so ignoring it is observable.
    logic [33:0] alu_r;
    always_comb begin
        alu_r      = ref_alu(alu_a, alu_b, alu_control);
        alu_result = alu_r[33] ? 32'hDEAD_BEEF : alu_r[31:0];
        alu_zero   = alu_r[33] ? 1'b1 : alu_r[32];
    end

    // Scoreboard and hold-stability monitor.
    exp_t        m_e;
    logic [33:0] m_r;
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", 64'(rsp_valid), 64'd1);
                chk("hold_data", 64'(rsp_data), 64'(hold_d));
                chk("hold_tag", 64'(rsp_tag), 64'(hold_t));
            end
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    m_e = q.pop_front();
                    chk("rsp_data", 64'(rsp_data), 64'(m_e.d));
                    chk("rsp_zero", 64'(rsp_zero), 64'(m_e.z));
                    chk("rsp_err", 64'(rsp_err), 64'(m_e.e));
                    chk("rsp_tag", 64'(rsp_tag), 64'(m_e.t));
                    last_d = rsp_data;
                    last_z = rsp_zero;
                    last_e = rsp_err;
                    n_rsp++;
                end
            end
            if (cmd_valid && cmd_ready) begin
                m_r = ref_alu(cmd_a, cmd_b, cmd_op);
                q.push_back('{d: m_r[31:0], z: m_r[32], e: m_r[33], t: cmd_tag});
            end
            hold   = rsp_valid && !rsp_ready;
            hold_d = rsp_data;
            hold_t = rsp_tag;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [TAG_W-1:0] tag);
        logic ok;
        ok        = 1'b0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_tag   = tag;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("push_timeout", 64'(cmd_ready), 64'd1);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && !rsp_valid && q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("idle_timeout", 64'(busy), 64'd0);
        end
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    int base;

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        cmd_tag   = '0;
        rsp_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state after idling
        repeat (5) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_alu_b", 64'(alu_b), 64'd0);
        chk("rst_alu_ctl", 64'(alu_control), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        step();

        // Latency of a single SUB into an empty block
        rsp_ready = 1'b1;
        cmd_a     = 32'd5;
        cmd_b     = 32'd3;
        cmd_op    = 4'b0110;
        cmd_tag   = 4'd2;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("lat_ready", 64'(cmd_ready), 64'd1);
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("lat_n1_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("lat_n2_valid", 64'(rsp_valid), 64'd0);
        chk("lat_n2_alu_a", 64'(alu_a), 64'd5);
        chk("lat_n2_alu_ctl", 64'(alu_control), 64'd6);
        @(negedge clk);
        chk("lat_n3_valid", 64'(rsp_valid), 64'd1);
        chk("lat_n3_data", 64'(rsp_data), 64'd2);
        chk("lat_n3_zero", 64'(rsp_zero), 64'd0);
        chk("lat_n3_tag", 64'(rsp_tag), 64'd2);
        chk("lat_n3_err", 64'(rsp_err), 64'd0);
        wait_idle();

        // Fill with consumer stalled, then drain in order
        rsp_ready = 1'b0;
        base      = n_rsp;
        for (int i = 0; i <= DEPTH; i++) begin
            push(32'(100 + i), 32'(i), 4'b0010, TAG_W'(i));
        end
        @(negedge clk);
        chk("full_count", 64'(count), 64'(DEPTH));
        chk("full_ready", 64'(cmd_ready), 64'd0);
        chk("full_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("full_rsp_tag", 64'(rsp_tag), 64'd0);
        repeat (3) @(negedge clk);
        chk("full_ready_hold", 64'(cmd_ready), 64'd0);
        step();
        rsp_ready = 1'b1;
        wait_idle();
        chk("full_rsp_n", 64'(n_rsp - base), 64'(DEPTH + 1));

        // Zero flag, illegal op and perf counters
        do_reset();
        push(32'd7, 32'd7, 4'b0110, 4'd3);
        wait_idle();
        chk("zero_data", 64'(last_d), 64'd0);
        chk("zero_flag", 64'(last_z), 64'd1);
        push(32'd9, 32'd1, 4'b0011, 4'd4);
        wait_idle();
        chk("ill_err", 64'(last_e), 64'd1);
        chk("ill_data", 64'(last_d), 64'd0);
        chk("ill_zero", 64'(last_z), 64'd0);
`ifdef ALU_ISSUER_PERF_EN
        chk("perf_ops", 64'(perf_ops), 64'd2);
        chk("perf_err", 64'(perf_err), 64'd1);
`endif

        // Shifts
        push(32'h8000_0000, 32'd4, 4'b1100, 4'd5);
        wait_idle();
        chk("sra", 64'(last_d), 64'hF800_0000);
        push(32'h8000_0000, 32'd4, 4'b1011, 4'd6);
        wait_idle();
        chk("srl", 64'(last_d), 64'h0800_0000);

        // Random traffic with random backpressure
        base       = n_rsp;
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) step();
            push($urandom, $urandom, 4'($urandom_range(0, 15)), TAG_W'(i));
        end
        wait_idle();
        rand_ready = 1'b0;
        step();
        rsp_ready = 1'b1;
        chk("rand_rsp_n", 64'(n_rsp - base), 64'd300);

        // Reset while holding a response with three queued
        rsp_ready = 1'b0;
        base      = n_rsp;
        for (int i = 0; i < 4; i++) begin
            push(32'(i), 32'd1, 4'b0010, TAG_W'(8 + i));
        end
        @(negedge clk);
        chk("mid_count", 64'(count), 64'd3);
        chk("mid_rsp_valid", 64'(rsp_valid), 64'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_count", 64'(count), 64'd0);
        chk("post_rst_valid", 64'(rsp_valid), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_ready", 64'(cmd_ready), 64'd1);
        step();
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_stale", 64'(rsp_valid), 64'd0);
        end
        chk("no_stale_n", 64'(n_rsp - base), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
